dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-ported data RAM between two requesters. Port 0 is the core load/store path. Port 1 is the debug/program-loader path.
- Round-robin arbitration, plus an optional per-requester lock for back-to-back bursts, bounded by a starvation guard.
- Sits between the requesters and the data RAM. Drives the RAM's write enable, read enable, address and write data. Steers the registered read data back to the requester that issued the read.

Parameters:
- ADDR_W, 8, RAM word address width.
- DATA_W, 32, data width.
- MAX_LOCK, 4, maximum consecutive grants to one locked owner before forced release (legal range 2..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req0  in  1  port 0 request; command fields must stay stable while req0=1 and gnt0=0
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- lock0  in  1  port 0 asks to keep ownership after this beat
- gnt0  out  1  port 0 beat accepted this cycle (combinational)
- rvalid0  out  1  port 0 read data valid
- rdata0  out  DATA_W  port 0 read data
- req1, we1, addr1, wdata1, lock1, gnt1, rvalid1, rdata1: same as port 0, for port 1
- mem_wen  out  1  RAM write enable
- mem_ren  out  1  RAM read enable
- mem_addr  out  ADDR_W  RAM address (used for both read and write)
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_ren

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, ptr=0 (port 0 preferred), lock_cnt=0.
  - rvalid0=rvalid1=0; pending-read tag cleared.
  - gnt0/gnt1 and all mem_* outputs are 0 while rst=1.
- Transfer rule: a beat transfers in a cycle where reqN=1 and gntN=1.
- Grant exclusivity: at most one of gnt0/gnt1 is high in any cycle.
- RAM drive, combinational in the grant cycle:
  - mem_addr=addrN, mem_wdata=wdataN.
  - mem_wen=weN, mem_ren=~weN.
  - With no grant: mem_wen=mem_ren=0, mem_addr=0, mem_wdata=0.
- Read return:
  - A granted read on port N registers tag=N.
  - The next cycle drives rvalidN=1 for exactly one cycle, with rdataN=mem_rdata.
  - rdata of the non-tagged port holds its last value.
  - A write produces no rvalid.
  - Latency is fixed at 1; a read can be granted every cycle (full throughput).
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - Only reqN high: grant N.
  - Both requests high: grant port ptr.
  - After any grant: ptr becomes the other port.
  - Granted with lockN=1: next state OWNN, lock_cnt=1.
  - Otherwise: stay in IDLE.
- OWNN:
  - Only port N can be granted; the other port's gnt is held 0.
  - On a grant with lockN=1: lock_cnt increments.
  - Leave to IDLE when any of these holds:
    - a grant with lockN=0;
    - reqN=0 in a cycle (no grant that cycle, ownership dropped);
    - the grant that brings lock_cnt to MAX_LOCK.
  - On leaving, ptr = the other port, so the waiting port wins the next contention.
- Simultaneous events:
  - A release and a new request from the other port in the same cycle: the other port waits one cycle (IDLE arbitration happens next cycle).
  - Both lock bits high in IDLE: only the winner's lock is honoured.
- Reset asserted mid-burst or with a read in flight:
  - The pending rvalid is dropped and ownership is lost.
  - No mem strobe is issued in the reset cycle.
- Address and data pass through unchanged; no width conversion. addr must be < 2^ADDR_W by construction.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_gnt0[15:0], stat_gnt1[15:0] (granted beats per port) and stat_wait[15:0] (cycles where some reqN=1 and gntN=0).
  - All three counters saturate at 16'hFFFF and clear on rst.
- Undefined: those ports and counters do not exist, and arbitration behaviour is identical.

Test Plan:
- Reset, then req0=1, we0=0, addr0=8'h10 with mem_rdata=32'hDEADBEEF the following cycle:
  - -> gnt0=1 in the request cycle with mem_ren=1, mem_addr=8'h10;
  - -> next cycle rvalid0=1, rdata0=32'hDEADBEEF; rvalid1 stays 0.
- req0 and req1 held high, no locks, for 6 cycles:
  - -> grants alternate 0,1,0,1,0,1 (ptr starts at 0);
  - -> never both gnt high.
- Port 1 burst with lock1=1 on 4 write beats to addr 0..3, data 1..4, while req0 is held high:
  - -> gnt1 for 4 consecutive cycles, gnt0=0 throughout;
  - -> state returns to IDLE on the 4th beat (MAX_LOCK=4) and port 0 is granted next.
- Port 0 locked burst with lock0 dropped on beat 2:
  - -> ownership released after beat 2;
  - -> pending req1 granted on the following cycle.
- Read granted to port 1 with rst asserted the next cycle:
  - -> rvalid1 stays 0, gnt0/gnt1=0 and mem_* outputs are 0 during reset;
  - -> the first grant after reset goes to port 0 under contention.
- With DMEM_ARB_STATS_EN defined, the 6-cycle alternation scenario:
  - -> stat_gnt0=3, stat_gnt1=3, stat_wait=6;
  - -> all three read 0 after rst.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-RAM port of dmem_arbiter.
// The arbiter attaches through the slave modport; requesters and the RAM
// model sit on the master side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();
    // port 0: core load/store path
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              lock0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;
    // port 1: debug / program-loader path
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              lock1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;
    // single-ported data RAM
    logic              mem_wen;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0, lock0,
        output gnt0, rvalid0, rdata0,
        input  req1, we1, addr1, wdata1, lock1,
        output gnt1, rvalid1, rdata1,
        output mem_wen, mem_ren, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0, we0, addr0, wdata0, lock0,
        input  gnt0, rvalid0, rdata0,
        output req1, we1, addr1, wdata1, lock1,
        input  gnt1, rvalid1, rdata1,
        input  mem_wen, mem_ren, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data RAM.
// A requester may hold ownership for back-to-back beats via its lock bit,
// capped at MAX_LOCK consecutive grants so the other port cannot starve.
// Optional grant/wait statistics counters: define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_gnt0,
    output logic [15:0]   stat_gnt1,
    output logic [15:0]   stat_wait
`endif
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [4:0] LOCK_LIMIT = 5'(MAX_LOCK);

    state_t            state_reg, state_next;
    logic              ptr_reg, ptr_next;
    logic [3:0]        lock_cnt_reg, lock_cnt_next;
    logic              grant0, grant1;
    logic              gnt0, gnt1;
    logic              rvalid0_reg, rvalid1_reg;
    logic [DATA_W-1:0] rdata0_reg, rdata1_reg;
    logic              more_beats;

    // State, round-robin pointer and lock counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= 1'b0;
            lock_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            lock_cnt_reg <= lock_cnt_next;
        end
    end

    // Next-state, grant selection and lock bookkeeping
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        lock_cnt_next = lock_cnt_reg;
        grant0        = 1'b0;
        grant1        = 1'b0;
        // another locked beat is allowed only if it stays below the cap
        more_beats    = ({1'b0, lock_cnt_reg} + 5'd1) < LOCK_LIMIT;
        case (state_reg)
            IDLE: begin
                if (bus.req0 && (!bus.req1 || !ptr_reg)) begin
                    grant0   = 1'b1;
                    ptr_next = 1'b1;
                    if (bus.lock0) begin
                        state_next    = OWN0;
                        lock_cnt_next = 4'd1;
                    end
                end else if (bus.req1) begin
                    grant1   = 1'b1;
                    ptr_next = 1'b0;
                    if (bus.lock1) begin
                        state_next    = OWN1;
                        lock_cnt_next = 4'd1;
                    end
                end
            end
            OWN0: begin
                grant0 = bus.req0;
                if (bus.req0 && bus.lock0 && more_beats) begin
                    lock_cnt_next = lock_cnt_reg + 4'd1;
                end else begin
                    // unlocked beat, dropped request or cap reached
                    state_next    = IDLE;
                    ptr_next      = 1'b1;
                    lock_cnt_next = 4'd0;
                end
            end
            OWN1: begin
                grant1 = bus.req1;
                if (bus.req1 && bus.lock1 && more_beats) begin
                    lock_cnt_next = lock_cnt_reg + 4'd1;
                end else begin
                    state_next    = IDLE;
                    ptr_next      = 1'b0;
                    lock_cnt_next = 4'd0;
                end
            end
            default: begin
                state_next    = IDLE;
                lock_cnt_next = 4'd0;
            end
        endcase
    end

    // Grants are suppressed while reset is held so no RAM strobe leaks out
    assign gnt0     = grant0 & ~rst;
    assign gnt1     = grant1 & ~rst;
    assign bus.gnt0 = gnt0;
    assign bus.gnt1 = gnt1;

    // RAM command mux: granted port drives the RAM, otherwise all zero
    always_comb begin
        bus.mem_wen   = 1'b0;
        bus.mem_ren   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (gnt0) begin
            bus.mem_wen   = bus.we0;
            bus.mem_ren   = ~bus.we0;
            bus.mem_addr  = bus.addr0;
            bus.mem_wdata = bus.wdata0;
        end else if (gnt1) begin
            bus.mem_wen   = bus.we1;
            bus.mem_ren   = ~bus.we1;
            bus.mem_addr  = bus.addr1;
            bus.mem_wdata = bus.wdata1;
        end
    end

    // Read-return tag and per-port read-data hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0_reg <= 1'b0;
            rvalid1_reg <= 1'b0;
            rdata0_reg  <= '0;
            rdata1_reg  <= '0;
        end else begin
            rvalid0_reg <= gnt0 & ~bus.we0;
            rvalid1_reg <= gnt1 & ~bus.we1;
            if (rvalid0_reg) rdata0_reg <= bus.mem_rdata;
            if (rvalid1_reg) rdata1_reg <= bus.mem_rdata;
        end
    end

    // RAM data arrives in the rvalid cycle; a reset in that cycle drops it
    assign bus.rvalid0 = rvalid0_reg & ~rst;
    assign bus.rvalid1 = rvalid1_reg & ~rst;
    assign bus.rdata0  = bus.rvalid0 ? bus.mem_rdata : rdata0_reg;
    assign bus.rdata1  = bus.rvalid1 ? bus.mem_rdata : rdata1_reg;

`ifdef DMEM_ARB_STATS_EN
    // Saturating grant and wait counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_gnt0 <= 16'd0;
            stat_gnt1 <= 16'd0;
            stat_wait <= 16'd0;
        end else begin
            if (gnt0 && stat_gnt0 != 16'hFFFF) stat_gnt0 <= stat_gnt0 + 16'd1;
            if (gnt1 && stat_gnt1 != 16'hFFFF) stat_gnt1 <= stat_gnt1 + 16'd1;
            if (((bus.req0 && !gnt0) || (bus.req1 && !gnt1)) && stat_wait != 16'hFFFF)
                stat_wait <= stat_wait + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (MAX_LOCK=4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_gnt0, stat_gnt1, stat_wait;
`endif

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_LOCK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_gnt0 (stat_gnt0),
        .stat_gnt1 (stat_gnt1),
        .stat_wait (stat_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0; bus.lock0 = 0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0; bus.lock1 = 0;
        bus.mem_rdata = '0;
    endtask

    task automatic check_mem_quiet(input string tag);
        check({tag, ".mem_wen"},   32'(bus.mem_wen),   32'd0);
        check({tag, ".mem_ren"},   32'(bus.mem_ren),   32'd0);
        check({tag, ".mem_addr"},  32'(bus.mem_addr),  32'd0);
        check({tag, ".mem_wdata"}, bus.mem_wdata,      32'd0);
    endtask

    initial begin
        logic exp0;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();

        // ---- reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst.gnt0",    32'(bus.gnt0),    32'd0);
        check("rst.gnt1",    32'(bus.gnt1),    32'd0);
        check("rst.rvalid0", 32'(bus.rvalid0), 32'd0);
        check("rst.rvalid1", 32'(bus.rvalid1), 32'd0);
        check_mem_quiet("rst");

        // ---- single read on port 0
        @(negedge clk);
        rst = 1'b0;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h10;
        #1;
        check("rd0.gnt0",     32'(bus.gnt0),     32'd1);
        check("rd0.gnt1",     32'(bus.gnt1),     32'd0);
        check("rd0.mem_ren",  32'(bus.mem_ren),  32'd1);
        check("rd0.mem_wen",  32'(bus.mem_wen),  32'd0);
        check("rd0.mem_addr", 32'(bus.mem_addr), 32'h10);
        @(negedge clk);
        bus.req0 = 0;
        bus.mem_rdata = 32'hDEADBEEF;
        #1;
        check("rd0.rvalid0", 32'(bus.rvalid0), 32'd1);
        check("rd0.rdata0",  bus.rdata0,       32'hDEADBEEF);
        check("rd0.rvalid1", 32'(bus.rvalid1), 32'd0);
        check("rd0.gnt0_idle", 32'(bus.gnt0),  32'd0);
        @(negedge clk);
        bus.mem_rdata = 32'h0;
        #1;
        check("rd0.rvalid0_one", 32'(bus.rvalid0), 32'd0);
        check("rd0.rdata0_hold", bus.rdata0,       32'hDEADBEEF);

        // ---- reset again so the pointer starts at port 0
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`ifdef DMEM_ARB_STATS_EN
        #1;
        check("stats.rst.gnt0", 32'(stat_gnt0), 32'd0);
        check("stats.rst.gnt1", 32'(stat_gnt1), 32'd0);
        check("stats.rst.wait", 32'(stat_wait), 32'd0);
`endif

        // ---- both requesting, no locks: strict alternation 0,1,0,1,0,1
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clk);
            bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'(8'h40 + i); bus.wdata0 = 32'(100 + i);
            bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'(8'h80 + i); bus.wdata1 = 32'(200 + i);
            #1;
            exp0 = (i % 2 == 0);
            check($sformatf("alt%0d.gnt0", i), 32'(bus.gnt0), 32'(exp0));
            check($sformatf("alt%0d.gnt1", i), 32'(bus.gnt1), 32'(!exp0));
            check($sformatf("alt%0d.excl", i), 32'(bus.gnt0 & bus.gnt1), 32'd0);
            check($sformatf("alt%0d.addr", i), 32'(bus.mem_addr),
                  exp0 ? 32'(8'h40 + i) : 32'(8'h80 + i));
            check($sformatf("alt%0d.wdata", i), bus.mem_wdata,
                  exp0 ? 32'(100 + i) : 32'(200 + i));
            check($sformatf("alt%0d.wen", i), 32'(bus.mem_wen), 32'd1);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check("alt.rvalid0_none", 32'(bus.rvalid0), 32'd0);
        check("alt.rvalid1_none", 32'(bus.rvalid1), 32'd0);
`ifdef DMEM_ARB_STATS_EN
        check("stats.gnt0", 32'(stat_gnt0), 32'd3);
        check("stats.gnt1", 32'(stat_gnt1), 32'd3);
        check("stats.wait", 32'(stat_wait), 32'd6);
`endif

        // ---- port 0 beat first so the pointer moves to port 1
        @(negedge clk);
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h20; bus.wdata0 = 32'h55;
        bus.req1 = 1; bus.we1 = 1; bus.lock1 = 1; bus.addr1 = 8'd0; bus.wdata1 = 32'd1;
        #1;
        check("pre.gnt0", 32'(bus.gnt0), 32'd1);
        check("pre.gnt1", 32'(bus.gnt1), 32'd0);

        // ---- port 1 locked burst, capped at 4 beats while port 0 waits
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.addr1 = 8'(k); bus.wdata1 = 32'(k + 1);
            #1;
            check($sformatf("burst%0d.gnt1", k), 32'(bus.gnt1), 32'd1);
            check($sformatf("burst%0d.gnt0", k), 32'(bus.gnt0), 32'd0);
            check($sformatf("burst%0d.addr", k), 32'(bus.mem_addr), 32'(k));
            check($sformatf("burst%0d.wdata", k), bus.mem_wdata, 32'(k + 1));
        end

        // ---- forced release: port 0 wins, and starts its own locked burst
        @(negedge clk);
        bus.lock0 = 1;
        #1;
        check("rel.gnt0", 32'(bus.gnt0), 32'd1);
        check("rel.gnt1", 32'(bus.gnt1), 32'd0);

        // beat 2 of port 0: lock dropped, still owned this cycle
        @(negedge clk);
        bus.lock0 = 0; bus.lock1 = 0;
        #1;
        check("own0.b2.gnt0", 32'(bus.gnt0), 32'd1);
        check("own0.b2.gnt1", 32'(bus.gnt1), 32'd0);

        // ownership released: waiting port 1 wins the contention
        @(negedge clk);
        #1;
        check("own0.after.gnt1", 32'(bus.gnt1), 32'd1);
        check("own0.after.gnt0", 32'(bus.gnt0), 32'd0);

        // ---- read on port 1 then reset the following cycle
        @(negedge clk);
        bus.req0 = 0;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h33;
        #1;
        check("rstrd.gnt1",    32'(bus.gnt1),    32'd1);
        check("rstrd.mem_ren", 32'(bus.mem_ren), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h44;
        bus.mem_rdata = 32'hCAFEF00D;
        #1;
        check("rstrd.rvalid1", 32'(bus.rvalid1), 32'd0);
        check("rstrd.gnt0",    32'(bus.gnt0),    32'd0);
        check("rstrd.gnt1",    32'(bus.gnt1),    32'd0);
        check_mem_quiet("rstrd");
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rdata = 32'h0;
        #1;
        check("post.rvalid1", 32'(bus.rvalid1), 32'd0);
        check("post.gnt0",    32'(bus.gnt0),    32'd1);
        check("post.gnt1",    32'(bus.gnt1),    32'd0);
        check("post.rdata1",  bus.rdata1,       32'd0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
